// File: rtl/io_port_arbiter.sv
// io_port_arbiter
// ---------------------------------------------------------------------------
// Two-requester arbiter and sequencer in front of the memory-mapped IO
// peripheral (status, LED and switch ports) of the single-cycle MIPS system.
// Requester 0 is the CPU data-bus side, requester 1 an auxiliary master.
// Each granted access takes three cycles:
//   IDLE  : sample requests, latch the winner's command into the outputs
//   ISSUE : peripheral strobe is high for exactly this cycle
//   ACK   : one-cycle acknowledge to the winner with the captured read data
//
// Optional build macro:
//   IO_ARB_FIXED_PRIO_EN - when defined, requester 0 always wins a tie.
//                          Otherwise arbitration is round-robin on `owner`.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req0/req1             request, held until the matching ack
//   rd0/rd1, wr0/wr1      read / write command, valid with req
//   addr0/addr1           peripheral port select
//   wdata0/wdata1         write data
//   ack0/ack1             one-cycle completion pulse
//   rdata                 read result, valid with ack, held otherwise
//   pRead, pWrite         peripheral strobes (registered)
//   addr, pWriteData      peripheral address / write data (registered)
//   pReadData             combinational read data from the peripheral
//   busy                  high in ISSUE and ACK
//   owner                 requester currently or last granted
// ---------------------------------------------------------------------------
module io_port_arbiter #(
  parameter int ADDR_W  = 2,
  parameter int WDATA_W = 12,
  parameter int RDATA_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0,
  input  logic               req1,
  input  logic               rd0,
  input  logic               rd1,
  input  logic               wr0,
  input  logic               wr1,
  input  logic [ADDR_W-1:0]  addr0,
  input  logic [ADDR_W-1:0]  addr1,
  input  logic [WDATA_W-1:0] wdata0,
  input  logic [WDATA_W-1:0] wdata1,
  output logic               ack0,
  output logic               ack1,
  output logic [RDATA_W-1:0] rdata,
  output logic               pRead,
  output logic               pWrite,
  output logic [ADDR_W-1:0]  addr,
  output logic [WDATA_W-1:0] pWriteData,
  input  logic [RDATA_W-1:0] pReadData,
  output logic               busy,
  output logic               owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic                owner_reg, owner_next;
  logic                pread_reg, pread_next;
  logic                pwrite_reg, pwrite_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [WDATA_W-1:0]  wdata_reg, wdata_next;
  logic [RDATA_W-1:0]  rdata_reg, rdata_next;
  logic [1:0]          ack_reg, ack_next;
  logic                busy_reg, busy_next;

  // Requester inputs gathered into indexable form.
  logic [1:0]          req_vec;
  logic [1:0]          rd_vec;
  logic [1:0]          wr_vec;
  logic [ADDR_W-1:0]   addr_vec  [2];
  logic [WDATA_W-1:0]  wdata_vec [2];
  logic                winner;

  assign req_vec      = {req1, req0};
  assign rd_vec       = {rd1, rd0};
  assign wr_vec       = {wr1, wr0};
  assign addr_vec[0]  = addr0;
  assign addr_vec[1]  = addr1;
  assign wdata_vec[0] = wdata0;
  assign wdata_vec[1] = wdata1;

  // Winner selection. With a single requester, that requester wins; the
  // tie-break is the only thing the build option changes.
`ifdef IO_ARB_FIXED_PRIO_EN
  assign winner = ~req_vec[0];
`else
  assign winner = (req_vec == 2'b11) ? ~owner_reg : req_vec[1];
`endif

  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    pread_next  = 1'b0;
    pwrite_next = 1'b0;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    rdata_next  = rdata_reg;
    ack_next    = 2'b00;
    busy_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (|req_vec) begin
          // rd+wr together is a write; neither is a null transaction that
          // still walks through ISSUE/ACK without a strobe.
          pread_next  = rd_vec[winner] & ~wr_vec[winner];
          pwrite_next = wr_vec[winner];
          addr_next   = addr_vec[winner];
          wdata_next  = wdata_vec[winner];
          owner_next  = winner;
          busy_next   = 1'b1;
          state_next  = ISSUE;
        end
      end
      ISSUE: begin
        // Peripheral read data is combinational, so capture it at the end
        // of the strobe cycle.
        rdata_next         = pread_reg ? pReadData : '0;
        ack_next[owner_reg] = 1'b1;
        busy_next          = 1'b1;
        state_next         = ACK;
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      owner_reg  <= 1'b1;   // requester 0 wins the first tie
      pread_reg  <= 1'b0;
      pwrite_reg <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
      ack_reg    <= 2'b00;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      pread_reg  <= pread_next;
      pwrite_reg <= pwrite_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      rdata_reg  <= rdata_next;
      ack_reg    <= ack_next;
      busy_reg   <= busy_next;
    end
  end

  assign ack0       = ack_reg[0];
  assign ack1       = ack_reg[1];
  assign rdata      = rdata_reg;
  assign pRead      = pread_reg;
  assign pWrite     = pwrite_reg;
  assign addr       = addr_reg;
  assign pWriteData = wdata_reg;
  assign busy       = busy_reg;
  assign owner      = owner_reg;

endmodule

// File: tb/tb_io_port_arbiter.sv
// tb_io_port_arbiter
// Self-checking bench for io_port_arbiter. A transaction-level reference
// tracks the last grantee and predicts grant order, strobes, ack timing and
// read data; a small array stands in for the peripheral's read ports.
module tb_io_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_v, rd_v, wr_v;
  logic [1:0]  addr_v  [2];
  logic [11:0] wdata_v [2];
  logic        ack0, ack1, pRead, pWrite, busy, owner;
  logic [31:0] rdata, pReadData;
  logic [1:0]  addr;
  logic [11:0] pWriteData;
  logic [31:0] stub_mem [4];

  int vectors     = 0;
  int miscompares = 0;
  int txn_count   = 0;
  int last_grant  = 1;
  logic [31:0] rdata_hold = 32'd0;
  int grant_log[$];

  always #5 clk = ~clk;

  assign pReadData = stub_mem[addr];

  io_port_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req_v[0]), .req1(req_v[1]),
    .rd0(rd_v[0]), .rd1(rd_v[1]),
    .wr0(wr_v[0]), .wr1(wr_v[1]),
    .addr0(addr_v[0]), .addr1(addr_v[1]),
    .wdata0(wdata_v[0]), .wdata1(wdata_v[1]),
    .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .pRead(pRead), .pWrite(pWrite), .addr(addr), .pWriteData(pWriteData),
    .pReadData(pReadData), .busy(busy), .owner(owner)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: sole requester wins; on a tie, the one that was
  // not granted last (or always 0 with fixed priority).
  function automatic int pick(input logic r0, input logic r1);
    if (r0 && r1) begin
`ifdef IO_ARB_FIXED_PRIO_EN
      return 0;
`else
      return (last_grant == 0) ? 1 : 0;
`endif
    end
    return r0 ? 0 : 1;
  endfunction

  task automatic set_req(input int i, input logic r, input logic rd, input logic wr,
                         input logic [1:0] a, input logic [11:0] d);
    req_v[i] = r; rd_v[i] = rd; wr_v[i] = wr; addr_v[i] = a; wdata_v[i] = d;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_pread"},  32'(pRead),  32'd0);
    chk({tag, "_pwrite"}, 32'(pWrite), 32'd0);
    chk({tag, "_ack0"},   32'(ack0),   32'd0);
    chk({tag, "_ack1"},   32'(ack1),   32'd0);
    chk({tag, "_busy"},   32'(busy),   32'd0);
    chk({tag, "_rdata"},  rdata,       rdata_hold);
  endtask

  // One arbitration slot, entered during an IDLE cycle with inputs set.
  task automatic round(input bit drop, input bit scramble);
    int w;
    logic erd, ewr;
    logic [1:0] ea;
    logic [11:0] ed;
    logic [31:0] exp_rd;
    @(posedge clk); #1;
    if (req_v == 2'b00) begin
      check_quiet("idle");
      return;
    end
    w   = pick(req_v[0], req_v[1]);
    erd = rd_v[w] & ~wr_v[w];
    ewr = wr_v[w];
    ea  = addr_v[w];
    ed  = wdata_v[w];
    last_grant = w;
    exp_rd = erd ? stub_mem[ea] : 32'd0;
    chk("issue_pread",  32'(pRead),      32'(erd));
    chk("issue_pwrite", 32'(pWrite),     32'(ewr));
    chk("issue_addr",   32'(addr),       32'(ea));
    chk("issue_wdata",  32'(pWriteData), 32'(ed));
    chk("issue_busy",   32'(busy),       32'd1);
    chk("issue_owner",  32'(owner),      32'(w));
    chk("issue_ack",    32'({ack1, ack0}), 32'd0);
    if (drop) req_v[w] = 1'b0;
    if (scramble) begin
      for (int i = 0; i < 2; i++)
        set_req(i, req_v[i], 1'($urandom), 1'($urandom), 2'($urandom), 12'($urandom));
    end
    @(posedge clk); #1;
    chk("ack_ack0",   32'(ack0),       (w == 0) ? 32'd1 : 32'd0);
    chk("ack_ack1",   32'(ack1),       (w == 1) ? 32'd1 : 32'd0);
    chk("ack_rdata",  rdata,           exp_rd);
    chk("ack_strobe", 32'({pRead, pWrite}), 32'd0);
    chk("ack_busy",   32'(busy),       32'd1);
    chk("ack_addr",   32'(addr),       32'(ea));
    chk("ack_wdata",  32'(pWriteData), 32'(ed));
    rdata_hold = exp_rd;
    grant_log.push_back(w);
    $display("txn %0d: grant=%0d rd=%0b wr=%0b addr=%0d wdata=%h rdata=%h",
             txn_count, w, erd, ewr, ea, ed, rdata);
    txn_count++;
    @(posedge clk); #1;
    check_quiet("post_ack");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order [4];
    int n;
    reset = 1'b1;
    set_req(0, 0, 0, 0, 2'd0, 12'd0);
    set_req(1, 0, 0, 0, 2'd0, 12'd0);
    for (int i = 0; i < 4; i++) stub_mem[i] = 32'h1000_0000 + 32'(i);
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    chk("reset_addr",  32'(addr),       32'd0);
    chk("reset_wdata", 32'(pWriteData), 32'd0);
    chk("reset_owner", 32'(owner),      32'd1);
    reset = 1'b0;

    // Write from requester 0.
    set_req(0, 1, 0, 1, 2'b01, 12'hABC);
    round(0, 0);
    req_v[0] = 1'b0;

    // Read from requester 1.
    stub_mem[2] = 32'h0000_005A;
    set_req(1, 1, 1, 0, 2'b10, 12'h000);
    round(0, 0);
    req_v[1] = 1'b0;

    // Both held with reads for four slots.
    set_req(0, 1, 1, 0, 2'd0, 12'h111);
    set_req(1, 1, 1, 0, 2'd3, 12'h222);
    n = grant_log.size();
    for (int i = 0; i < 4; i++) round(0, 0);
`ifdef IO_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    for (int i = 0; i < 4; i++) chk("rr_order", 32'(grant_log[n + i]), 32'(exp_order[i]));
    req_v = 2'b00;

    // rd+wr together, then a null transaction.
    set_req(0, 1, 1, 1, 2'd3, 12'h5C3);
    round(0, 0);
    set_req(0, 1, 0, 0, 2'd1, 12'h00F);
    round(0, 0);
    req_v[0] = 1'b0;

    // Reset during ISSUE of a requester-1 read.
    set_req(1, 1, 1, 0, 2'd2, 12'h000);
    @(posedge clk); #1;
    chk("rst_issue_pread", 32'(pRead), 32'd1);
    reset = 1'b1;
    req_v[1] = 1'b0;
    @(posedge clk); #1;
    rdata_hold = 32'd0;
    check_quiet("rst_mid");
    chk("rst_mid_addr",  32'(addr),  32'd0);
    chk("rst_mid_owner", 32'(owner), 32'd1);
    reset = 1'b0;
    last_grant = 1;
    @(posedge clk); #1;
    check_quiet("rst_after");
    set_req(0, 1, 1, 0, 2'd1, 12'h000);
    round(0, 0);

    // Requester drops req during ISSUE.
    set_req(0, 1, 0, 1, 2'd2, 12'h777);
    round(1, 0);
    round(0, 0);

    // Randomised traffic.
    for (int k = 0; k < 60; k++) begin
      for (int i = 0; i < 4; i++) stub_mem[i] = $urandom;
      for (int i = 0; i < 2; i++)
        set_req(i, 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                2'($urandom), 12'($urandom));
      round(1'($urandom_range(0, 3) == 0), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
